lane_round_robin_scheduler: RTL and testbench
=============================================

# lane_round_robin_scheduler

Round-robin scheduler that shares the single 9-bit serial lane word path (MSB = valid, low 8 bits = payload) among four lane sources. Each cycle it picks at most one requesting lane, pops one word from that lane's show-ahead FIFO and registers it onto the shared output with a lane tag. The output drives the demux stage in the clk4f domain. Bursts of up to BURST consecutive words per lane bound latency and stop any lane from starving the others.

## Interface
- BW, 8, payload width; every word is BW+1 bits with bit BW = valid.
- BURST, 2, max consecutive pops granted to one lane before rotation; legal range 1..15.

- clk4f  in  1  single clock; all state on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req  in  4  req[i]=1: lane i FIFO non-empty; its head word is on data_i (show-ahead).
- data0, data1, data2, data3  in  BW+1  head word of lane 0..3.
- pause  in  1  downstream cannot accept; no pop while high.
- pop  out  4  one-hot pop strobe to lane FIFOs, combinational from state/req/pause; forced 0 while reset_L=0.
- data_out  out  BW+1  registered output word.
- lane_out  out  2  registered lane index of data_out.
- busy  out  1  registered; 1 while a lane owns the path (state OWN).

## Operation
- State: IDLE / OWN; owner cur (2b); burst count cnt (4b); all cleared asynchronously on reset_L=0 (IDLE, cur=3, cnt=0).
- Outputs at reset: data_out=0, lane_out=0, busy=0, pop=0.
- Round-robin pick: first lane with req=1 searched from cur+1 upward, mod 4. After reset the search starts at lane 0.
- Grant cycle (pause=0, pick exists): pop[lane]=1. At the edge: data_out <= data_lane unchanged (valid bit passed through), lane_out <= lane, cur <= lane, cnt <= 1, state <= OWN.
- IDLE, pause=0, req=0: stay IDLE; data_out[BW] <= 0.
- OWN, pause=0:
  - req[cur]=1 and cnt<BURST: pop cur again; cnt <= cnt+1.
  - otherwise, if any req: new round-robin pick starting at cur+1. The pick may return cur when cur is the only requester; cnt <= 1.
  - no req: state <= IDLE, cur kept, data_out[BW] <= 0.
- pause=1 (any state): pop=0. State, cur and cnt hold. data_out[BW] <= 0, data_out payload and lane_out hold.
- A popped word whose own valid bit is 0 is forwarded as-is (data_out[BW]=0). It still counts toward cnt.
- BURST=1: strict rotation each cycle.
- No word is duplicated or dropped: exactly one pop per output word, order within a lane preserved.

## Timing
- Latency 1 cycle: pop asserted in cycle N, matching word on data_out/lane_out after the rising edge ending cycle N.
- pop reacts combinationally to req and pause in the same cycle. It never goes high on a lane with req=0 and never has more than one bit set.
- busy updates on the same edge as the state.
- Throughput: one word per cycle while pause=0 and any req=1.
- Worst-case wait for a requesting lane: 3*BURST cycles of other traffic plus pause cycles.
- reset_L low mid-burst: immediate clear of outputs and pop. First grant after release follows the lane-0-first rule.

## Test plan
- Reset: reset_L=0, req=4'hF, data words nonzero -> pop=0, data_out=9'h000, lane_out=0, busy=0; after release, first pop=4'b0001.
- Single lane: BURST=2, req=4'b0001, data0=9'h10C held 4 cycles -> pop=0001 every cycle; data_out=9'h10C, lane_out=0 from the cycle after first pop; cnt reloads to 1 every 2 pops.
- All lanes: BURST=2, req=4'hF, data0..3=9'h10C/10F/111/117 -> lane_out sequence 0,0,1,1,2,2,3,3,0; data_out tracks the matching words.
- Pause mid-burst: same stimulus, pause=1 for 2 cycles after the first lane-1 pop -> pop=0 and data_out[8]=0 for 2 cycles; next pop is lane 1 (cnt=2), then lane 2.
- Invalid word pass-through and BURST=1: req=4'b0101, data0=9'h10C, data2=9'h011 -> lanes alternate 0,2,0,2; data_out alternates 9'h10C/9'h011.
- Reset mid-burst: assert reset_L=0 during a lane-2 burst -> pop=0 and data_out=0 that same cycle; after release, lane 0 is served first if req[0]=1.

Source files
------------

// File: rtl/lane_round_robin_scheduler_if.sv
// Shared lane word path between the four lane FIFOs and the round-robin scheduler.
// Lane-facing handshake plus the registered output word toward the clk4f demux stage.
interface lane_round_robin_scheduler_if #(
  parameter int BW = 8
);
  logic [3:0]  req;
  logic [BW:0] data0;
  logic [BW:0] data1;
  logic [BW:0] data2;
  logic [BW:0] data3;
  logic        pause;
  logic [3:0]  pop;
  logic [BW:0] data_out;
  logic [1:0]  lane_out;
  logic        busy;

  modport master (
    output req, data0, data1, data2, data3, pause,
    input  pop, data_out, lane_out, busy
  );

  modport slave (
    input  req, data0, data1, data2, data3, pause,
    output pop, data_out, lane_out, busy
  );
endinterface

// File: rtl/lane_round_robin_scheduler.sv
// Round-robin scheduler sharing one serial lane word path among four show-ahead lane FIFOs.
// A lane keeps the path for up to BURST consecutive pops before the grant rotates.
module lane_round_robin_scheduler #(
  parameter int BW    = 8,
  parameter int BURST = 2
) (
  input  logic                          clk4f,
  input  logic                          reset_L,
  lane_round_robin_scheduler_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [1:0]  cur_q;
  logic [3:0]  cnt_q;
  logic [BW:0] data_out_q;
  logic [1:0]  lane_out_q;
  logic        busy_q;

  logic [2:0]  pick_s;
  logic        keep_d;
  logic        grant_d;
  logic [1:0]  lane_d;
  logic [BW:0] word_d;
  logic [3:0]  pop_s;

  // Returns {found, lane}: first requester searched upward from last+1, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Grant decision: stay on the owner while its burst budget lasts, otherwise rotate.
  always_comb begin
    pick_s  = rr_pick(bus.req, cur_q);
    keep_d  = (state_q == OWN) && bus.req[cur_q] && (cnt_q < 4'(BURST));
    lane_d  = keep_d ? cur_q : pick_s[1:0];
    grant_d = !bus.pause && (keep_d || pick_s[2]);
  end

  // Head-word select for the granted lane.
  always_comb begin
    word_d = bus.data0;
    case (lane_d)
      2'd0:    word_d = bus.data0;
      2'd1:    word_d = bus.data1;
      2'd2:    word_d = bus.data2;
      2'd3:    word_d = bus.data3;
      default: word_d = bus.data0;
    endcase
  end

  // One-hot pop strobe, held low while reset is asserted.
  always_comb begin
    pop_s = 4'b0000;
    if (reset_L && grant_d) begin
      pop_s[lane_d] = 1'b1;
    end else begin
      pop_s = 4'b0000;
    end
  end

  // Scheduler state and registered output word.
  always_ff @(posedge clk4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      cur_q      <= 2'd3;
      cnt_q      <= 4'd0;
      data_out_q <= '0;
      lane_out_q <= 2'd0;
      busy_q     <= 1'b0;
    end else if (bus.pause) begin
      data_out_q[BW] <= 1'b0;
    end else if (grant_d) begin
      state_q    <= OWN;
      busy_q     <= 1'b1;
      cur_q      <= lane_d;
      cnt_q      <= keep_d ? (cnt_q + 4'd1) : 4'd1;
      data_out_q <= word_d;
      lane_out_q <= lane_d;
    end else begin
      // Nothing requested: release the path but remember the last owner for fairness.
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      data_out_q[BW] <= 1'b0;
    end
  end

  assign bus.pop      = pop_s;
  assign bus.data_out = data_out_q;
  assign bus.lane_out = lane_out_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lane_round_robin_scheduler.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor checks them.
// Instance u2 uses BURST=2, instance u1 uses BURST=1.
module tb_lane_round_robin_scheduler;

  logic clk;
  logic rst_n;

  lane_round_robin_scheduler_if #(.BW(8)) bus2 ();
  lane_round_robin_scheduler_if #(.BW(8)) bus1 ();

  lane_round_robin_scheduler #(.BW(8), .BURST(2)) u2 (
    .clk4f   (clk),
    .reset_L (rst_n),
    .bus     (bus2)
  );

  lane_round_robin_scheduler #(.BW(8), .BURST(1)) u1 (
    .clk4f   (clk),
    .reset_L (rst_n),
    .bus     (bus1)
  );

  typedef struct {
    int         step;
    logic       sel;
    logic [3:0] pop;
    logic [8:0] dout;
    logic [1:0] lane;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   step_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic sel, input logic rst, input logic [3:0] req, input logic pause,
                     input logic [3:0] e_pop, input logic [8:0] e_dout, input logic [1:0] e_lane,
                     input logic e_busy);
    exp_t e;
    rst_n = rst;
    if (sel) begin
      bus1.req   = req;
      bus1.pause = pause;
    end else begin
      bus2.req   = req;
      bus2.pause = pause;
    end
    e.step = step_n;
    e.sel  = sel;
    e.pop  = e_pop;
    e.dout = e_dout;
    e.lane = e_lane;
    e.busy = e_busy;
    exp_q.push_back(e);
    step_n++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT against the oldest pending expectation, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] g_pop;
      logic [8:0] g_dout;
      logic [1:0] g_lane;
      logic       g_busy;
      e      = exp_q.pop_front();
      g_pop  = e.sel ? bus1.pop      : bus2.pop;
      g_dout = e.sel ? bus1.data_out : bus2.data_out;
      g_lane = e.sel ? bus1.lane_out : bus2.lane_out;
      g_busy = e.sel ? bus1.busy     : bus2.busy;
      total += 4;
      if (g_pop !== e.pop) begin
        bad++;
        $display("FAIL step%0d pop: got %b want %b", e.step, g_pop, e.pop);
      end
      if (g_dout !== e.dout) begin
        bad++;
        $display("FAIL step%0d data_out: got %h want %h", e.step, g_dout, e.dout);
      end
      if (g_lane !== e.lane) begin
        bad++;
        $display("FAIL step%0d lane_out: got %0d want %0d", e.step, g_lane, e.lane);
      end
      if (g_busy !== e.busy) begin
        bad++;
        $display("FAIL step%0d busy: got %b want %b", e.step, g_busy, e.busy);
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    step_n = 0;
    rst_n  = 1'b0;
    bus2.req = 4'h0; bus2.pause = 1'b0;
    bus2.data0 = 9'h10C; bus2.data1 = 9'h10F; bus2.data2 = 9'h111; bus2.data3 = 9'h117;
    bus1.req = 4'h0; bus1.pause = 1'b0;
    bus1.data0 = 9'h10C; bus1.data1 = 9'h10F; bus1.data2 = 9'h011; bus1.data3 = 9'h117;
    @(posedge clk);
    #1;

    // Reset with all lanes requesting and nonzero data.
    cyc(1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 9'h000, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 9'h000, 2'd0, 1'b0);
    // All lanes, BURST=2: lanes 0,0,1,1,2,2,3,3,0,0,1.
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0001, 9'h000, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0010, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0010, 9'h10F, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0100, 9'h10F, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0100, 9'h111, 2'd2, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b1000, 9'h111, 2'd2, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b1000, 9'h117, 2'd3, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0001, 9'h117, 2'd3, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0010, 9'h10C, 2'd0, 1'b1);
    // Pause two cycles after the first lane-1 pop; lane 1 resumes with its second pop.
    cyc(1'b0, 1'b1, 4'hF, 1'b1, 4'b0000, 9'h10F, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b1, 4'b0000, 9'h00F, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0010, 9'h00F, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 4'b0100, 9'h10F, 2'd1, 1'b1);
    // No requests: fall back to IDLE, valid cleared, cur stays 2.
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 4'b0000, 9'h111, 2'd2, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 4'b0000, 9'h011, 2'd2, 1'b0);
    // Single lane 0: popped every cycle, burst counter reloads.
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 4'b0001, 9'h011, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    // Lane-2 burst, then reset mid-burst, then lane 0 first after release.
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 4'b0100, 9'h10C, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 4'b0100, 9'h111, 2'd2, 1'b1);
    cyc(1'b0, 1'b0, 4'h5, 1'b0, 4'b0000, 9'h000, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 4'b0001, 9'h000, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 4'b0001, 9'h10C, 2'd0, 1'b1);
    // BURST=1 strict rotation with an invalid lane-2 word forwarded as-is.
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 4'b0001, 9'h000, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 4'b0100, 9'h10C, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 4'b0001, 9'h011, 2'd2, 1'b1);
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 4'b0100, 9'h10C, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 4'b0000, 9'h011, 2'd2, 1'b1);
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 4'b0000, 9'h011, 2'd2, 1'b0);

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
